// File: rtl/ram_bist.sv
// ram_bist: march-style BIST engine driving a synchronous RAM (write pattern, read/compare, repeat inverted)
//   Ports: clk, rst (async active-high), start
//          ram_we/ram_addr/ram_din -> RAM, ram_dout <- RAM (registered read data)
//          busy, done (sticky), pass, err_count (saturating), fail_addr, fail_data
//   Optional macro RAM_BIST_ADDR_PATTERN_EN: pattern becomes PATTERN ^ addr to catch address aliasing.
module ram_bist #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);
  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d, fail_data_q, fail_data_d, p_cur;
  logic [ADDR_WIDTH+1:0] err_q, err_d, err_nxt;
  logic cmp_valid_q, cmp_valid_d, done_q, done_d, pass_q, pass_d, miscmp, last;
`ifdef RAM_BIST_ADDR_PATTERN_EN
  assign p_cur = PATTERN ^ DATA_WIDTH'(addr_q);
`else
  assign p_cur = PATTERN;
`endif
  assign last    = &addr_q;
  assign miscmp  = cmp_valid_q && (ram_dout != cmp_exp_q);
  assign err_nxt = (miscmp && !(&err_q)) ? err_q + 1'b1 : err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    addr_d      = (state_q inside {WR0, RD0, WR1, RD1}) ? addr_q + 1'b1 : addr_q;
    cmp_valid_d = state_q inside {RD0, RD1};
    cmp_addr_d  = addr_q;
    cmp_exp_d   = (state_q == RD1) ? ~p_cur : p_cur;
    err_d       = err_nxt;
    // only the first miscompare of a run is recorded
    fail_addr_d = (miscmp && err_q == '0) ? cmp_addr_q : fail_addr_q;
    fail_data_d = (miscmp && err_q == '0) ? ram_dout : fail_data_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = WR0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        err_d       = '0;
        fail_addr_d = '0;
        fail_data_d = '0;
      end
      WR0: state_d = last ? RD0 : WR0;
      RD0: state_d = last ? WR1 : RD0;
      WR1: state_d = last ? RD1 : WR1;
      RD1: state_d = last ? FIN : RD1;
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_nxt == '0);
      end
      default: state_d = IDLE;
    endcase
  end
  assign ram_we    = state_q inside {WR0, WR1};
  assign ram_addr  = addr_q;
  assign ram_din   = (state_q == WR0) ? p_cur : (state_q == WR1) ? ~p_cur : '0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed bench for ram_bist with a behavioural RAM that can inject stuck-at and aliasing faults
module tb_ram_bist;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       ram_we, busy, done, pass;
  logic [3:0] ram_addr, fail_addr;
  logic [7:0] ram_din, fail_data;
  logic [7:0] ram_dout = 8'h00;
  logic [5:0] err_count;
  logic [7:0] mem [16];
  int mode = 0;
  int n_cmp = 0, n_bad = 0;
  ram_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );
  always #5 clk = ~clk;
  // mode 1: bit0 of addr 5 stuck-at-1 on read; mode 2: writes to addr 7 also land in addr 3
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      if (mode == 2 && ram_addr == 4'd7) mem[3] <= ram_din;
    end else
      ram_dout <= (mode == 1 && ram_addr == 4'd5) ? (mem[ram_addr] | 8'h01) : mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run(input string nm, input bit dbl, input logic [31:0] e_err,
                     input logic [31:0] e_fa, input logic [31:0] e_fd, input logic [31:0] e_pass);
    int cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({nm, "_done_clr"}, done, 0);
    chk({nm, "_busy_on"}, busy, 1);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      start = dbl && cnt == 10;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_busy_len"}, cnt, 65);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_pass"}, pass, e_pass);
    chk({nm, "_err"}, err_count, e_err);
    chk({nm, "_faddr"}, fail_addr, e_fa);
    chk({nm, "_fdata"}, fail_data, e_fd);
  endtask
  initial begin
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_fdata", fail_data, 0);
    @(negedge clk) rst = 1'b0;
    run("clean", 0, 0, 0, 0, 1);
    mode = 1;
`ifdef RAM_BIST_ADDR_PATTERN_EN
    run("stuck", 0, 1, 5, 8'h51, 0);
`else
    run("stuck", 0, 1, 5, 8'hAB, 0);
`endif
    mode = 0;
    run("rerun", 0, 0, 0, 0, 1);
    run("dbl", 1, 0, 0, 0, 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_rd0_we", ram_we, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", ram_addr, 0);
    chk("arst_din", ram_din, 0);
    chk("arst_done", done, 0);
    @(negedge clk) rst = 1'b0;
    run("post_rst", 0, 0, 0, 0, 1);
    mode = 2;
`ifdef RAM_BIST_ADDR_PATTERN_EN
    run("alias", 0, 2, 3, 8'h52, 0);
`else
    run("alias", 0, 0, 0, 0, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
